// File: rtl/alu_decoder_if.sv
// Decoder-side bundle between the main control decoder and the ALU.
// The master drives the opcode fields and enable; the slave returns the ALU select.
interface alu_decoder_if;
  logic       en;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [2:0] ALUControl_q;
  logic       illegal_q;

  modport master (
    output en, ALUOp, funct3, funct7,
    input  ALUControl, illegal, ALUControl_q, illegal_q
  );

  modport slave (
    input  en, ALUOp, funct3, funct7,
    output ALUControl, illegal, ALUControl_q, illegal_q
  );
endinterface

// File: rtl/alu_decoder.sv
// RV32I ALU control decoder: ALUOp/funct3/funct7 -> 3-bit ALU select and an illegal flag.
// Zero-latency combinational outputs plus an enable-gated registered copy.
module alu_decoder (
  input  logic          clk,
  input  logic          rst_n,
  alu_decoder_if.slave  bus
);

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100,
    AluSlt = 3'b101,
    AluSll = 3'b110,
    AluSrl = 3'b111
  } alu_ctrl_e;

  localparam logic [6:0] F7Base = 7'h00;
  localparam logic [6:0] F7Alt  = 7'h20;

  alu_ctrl_e ctrl;
  logic      illegal;
  logic      f7_ok;

  always_comb begin
    ctrl    = AluAdd;
    illegal = 1'b0;
    // The alternate funct7 is only meaningful for ADD/SUB and SRL/SRA.
    f7_ok   = (bus.funct7 == F7Base) ||
              ((bus.funct7 == F7Alt) && ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101)));
    unique case (bus.ALUOp)
      2'b00: ctrl = AluAdd;
      2'b01: ctrl = AluSub;
      2'b10: begin
        illegal = ~f7_ok;
        unique case (bus.funct3)
          3'b000: ctrl = bus.funct7[5] ? AluSub : AluAdd;
          3'b001: ctrl = AluSll;
          3'b010: ctrl = AluSlt;
          3'b011: begin
            ctrl    = AluSlt;
            illegal = 1'b1;
          end
          3'b100: ctrl = AluXor;
          3'b101: begin
            ctrl = AluSrl;
            // SRA decodes as SRL but is flagged: no arithmetic shifter downstream.
            if (bus.funct7 == F7Alt) illegal = 1'b1;
          end
          3'b110: ctrl = AluOr;
          3'b111: ctrl = AluAnd;
          default: begin
            ctrl    = AluAdd;
            illegal = 1'b1;
          end
        endcase
      end
      2'b11: begin
        ctrl    = AluAdd;
        illegal = 1'b1;
      end
      default: begin
        ctrl    = AluAdd;
        illegal = 1'b1;
      end
    endcase
  end

  assign bus.ALUControl = ctrl;
  assign bus.illegal    = illegal;

  logic [2:0] ctrl_q;
  logic       illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= 3'b000;
      illegal_q <= 1'b0;
    end else if (bus.en) begin
      ctrl_q    <= ctrl;
      illegal_q <= illegal;
    end
  end

  assign bus.ALUControl_q = ctrl_q;
  assign bus.illegal_q    = illegal_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Directed bench for alu_decoder: combinational decode table, registered path and async reset.
module tb_alu_decoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_decoder_if bus ();

  alu_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.ALUOp  = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    #1;
  endtask

  // Combinational view packed as {illegal, ALUControl}.
  function automatic logic [3:0] comb_out();
    return {bus.illegal, bus.ALUControl};
  endfunction

  function automatic logic [3:0] reg_out();
    return {bus.illegal_q, bus.ALUControl_q};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    apply(2'b00, 3'b000, 7'h00);

    chk("reset_regs", reg_out(), 4'b0_000);

    chk("ldst_add",   comb_out(), 4'b0_000);
    apply(2'b01, 3'b000, 7'h00); chk("branch_sub", comb_out(), 4'b0_001);
    apply(2'b01, 3'b111, 7'h7f); chk("branch_ign", comb_out(), 4'b0_001);

    apply(2'b10, 3'b000, 7'h00); chk("r_add",  comb_out(), 4'b0_000);
    apply(2'b10, 3'b000, 7'h20); chk("r_sub",  comb_out(), 4'b0_001);
    apply(2'b10, 3'b111, 7'h00); chk("r_and",  comb_out(), 4'b0_010);
    apply(2'b10, 3'b110, 7'h00); chk("r_or",   comb_out(), 4'b0_011);
    apply(2'b10, 3'b001, 7'h00); chk("r_sll",  comb_out(), 4'b0_110);
    apply(2'b10, 3'b010, 7'h00); chk("r_slt",  comb_out(), 4'b0_101);
    apply(2'b10, 3'b100, 7'h00); chk("r_xor",  comb_out(), 4'b0_100);
    apply(2'b10, 3'b101, 7'h00); chk("r_srl",  comb_out(), 4'b0_111);
    apply(2'b10, 3'b011, 7'h00); chk("r_sltu", comb_out(), 4'b1_101);

    apply(2'b10, 3'b101, 7'h20); chk("r_sra",     comb_out(), 4'b1_111);
    apply(2'b10, 3'b000, 7'h01); chk("r_f7_bad",  comb_out(), 4'b1_000);
    apply(2'b10, 3'b000, 7'h21); chk("r_f7_b5",   comb_out(), 4'b1_001);
    apply(2'b10, 3'b111, 7'h20); chk("r_and_f7",  comb_out(), 4'b1_010);
    apply(2'b11, 3'b000, 7'h00); chk("rsvd",      comb_out(), 4'b1_000);
    apply(2'b00, 3'b011, 7'h55); chk("ldst_ign",  comb_out(), 4'b0_000);

    // Reset still held across a clock edge with en high.
    bus.en = 1'b1;
    apply(2'b10, 3'b000, 7'h20);
    @(posedge clk); #1;
    chk("reset_hold", reg_out(), 4'b0_000);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reg_sub", reg_out(), 4'b0_001);

    @(negedge clk);
    bus.en = 1'b0;
    apply(2'b11, 3'b000, 7'h00);
    @(posedge clk); #1;
    chk("reg_hold", reg_out(), 4'b0_001);

    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk); #1;
    chk("reg_illegal", reg_out(), 4'b1_000);

    @(negedge clk);
    apply(2'b10, 3'b000, 7'h20);
    @(posedge clk); #1;
    chk("reg_sub2", reg_out(), 4'b0_001);

    // Assert reset mid-cycle; registers clear before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", reg_out(), 4'b0_000);
    chk("async_comb", comb_out(), 4'b0_001);

    @(negedge clk);
    rst_n = 1'b1;
    apply(2'b10, 3'b110, 7'h00);
    @(posedge clk); #1;
    chk("post_rst_cap", reg_out(), 4'b0_011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
